// File: rtl/alu_pkg.sv
// Shared encodings and helpers for the serial reduction ALU.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_SUM    = 2'b00,
        OP_POPCNT = 2'b01,
        OP_MAX    = 2'b10,
        OP_MIN    = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    localparam int unsigned IDENT_W = 64;

    // Starting accumulator value for a mode; MIN starts from all-ones of the field width.
    function automatic logic [IDENT_W-1:0] identity(op_e op, int unsigned width);
        logic [IDENT_W-1:0] ones;
        ones = '1;
        if (op == OP_MIN) begin
            identity = ones >> (IDENT_W - width);
        end else begin
            identity = '0;
        end
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bus of the serial reduction ALU.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned N_OPS = 3
);
    localparam int unsigned OUT_W = WIDTH + $clog2(N_OPS);

    logic [WIDTH*N_OPS-1:0] in;
    logic [1:0]             op;
    logic                   in_valid;
    logic                   in_ready;
    logic [OUT_W-1:0]       result;
    logic [WIDTH-1:0]       sum;
    logic                   ovf;
    logic                   zero;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output in, op, in_valid, out_ready,
        input  in_ready, result, sum, ovf, zero, out_valid
    );

    modport slave (
        input  in, op, in_valid, out_ready,
        output in_ready, result, sum, ovf, zero, out_valid
    );

endinterface

// File: rtl/alu_step.sv
// One reduction step: combine the accumulator with a single operand field.
module alu_step
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned OUT_W = 6
) (
    input  logic [OUT_W-1:0] acc,
    input  logic [WIDTH-1:0] operand,
    input  op_e              op,
    output logic [OUT_W-1:0] acc_nxt_c
);

    localparam int unsigned PC_W = $clog2(WIDTH + 1);

    logic [PC_W-1:0]  ones_c;
    logic [OUT_W-1:0] opnd_c;

    assign opnd_c = OUT_W'(operand);

    // Population count of the operand field.
    always_comb begin
        ones_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            ones_c = ones_c + PC_W'(operand[i]);
        end
    end

    // Per-mode accumulate; compares are unsigned and ties keep the accumulator.
    always_comb begin
        acc_nxt_c = acc;
        unique case (op)
            OP_SUM:    acc_nxt_c = acc + opnd_c;
            OP_POPCNT: acc_nxt_c = acc + OUT_W'(ones_c);
            OP_MAX:    if (opnd_c > acc) acc_nxt_c = opnd_c;
            OP_MIN:    if (opnd_c < acc) acc_nxt_c = opnd_c;
            default:   acc_nxt_c = acc;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Serial reduction ALU: accepts N_OPS packed fields, folds one per cycle, holds the result.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned N_OPS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);

    localparam int unsigned OUT_W    = WIDTH + $clog2(N_OPS);
    localparam int unsigned IN_W     = WIDTH * N_OPS;
    localparam int unsigned IDX_W    = (N_OPS > 1) ? $clog2(N_OPS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OPS - 1);

    generate
        if (N_OPS < 1) begin : g_bad_n_ops
            $error("alu_seq: N_OPS must be at least 1");
        end
    endgenerate

    state_e           state, state_nxt;
    logic             accept_c, advance_c, finish_c, release_c;
    logic             last_c;
    logic [IN_W-1:0]  opnd_q;
    op_e              op_q;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] acc_nxt_c;
    logic [IDX_W-1:0] idx;
    logic [OUT_W-1:0] result_q;
    logic             ovf_q, zero_q, out_valid_q, in_ready_q;

    assign last_c = (idx == IDX_LAST);

    // Field 0 always sits at the bottom of the shifting operand register.
    alu_step #(
        .WIDTH (WIDTH),
        .OUT_W (OUT_W)
    ) u_step (
        .acc       (acc),
        .operand   (opnd_q[WIDTH-1:0]),
        .op        (op_q),
        .acc_nxt_c (acc_nxt_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (bus.in_valid)  state_nxt = S_RUN;
            S_RUN:   if (last_c)        state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control strobes per state; out_ready only matters while a result is held.
    always_comb begin
        accept_c  = 1'b0;
        advance_c = 1'b0;
        finish_c  = 1'b0;
        release_c = 1'b0;
        unique case (state)
            S_IDLE:  accept_c = bus.in_valid;
            S_RUN: begin
                advance_c = 1'b1;
                finish_c  = last_c;
            end
            S_DONE:  release_c = bus.out_ready;
            default: ;
        endcase
    end

    // Operand latch, accumulator and field index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd_q <= '0;
            op_q   <= OP_SUM;
            acc    <= '0;
            idx    <= '0;
        end else if (accept_c) begin
            opnd_q <= bus.in;
            op_q   <= op_e'(bus.op);
            acc    <= OUT_W'(identity(op_e'(bus.op), WIDTH));
            idx    <= '0;
        end else if (advance_c) begin
            opnd_q <= opnd_q >> WIDTH;
            acc    <= acc_nxt_c;
            idx    <= last_c ? '0 : idx + 1'b1;
        end
    end

    // Result, flags and handshake outputs; flags are taken from the final step, not from acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            if (accept_c) begin
                in_ready_q <= 1'b0;
            end
            if (finish_c) begin
                result_q    <= acc_nxt_c;
                ovf_q       <= (op_q == OP_SUM) && ((acc_nxt_c >> WIDTH) != '0);
                zero_q      <= (acc_nxt_c == '0);
                out_valid_q <= 1'b1;
            end
            if (release_c) begin
                out_valid_q <= 1'b0;
                in_ready_q  <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.result    = result_q;
    assign bus.sum       = result_q[WIDTH-1:0];
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, handshake corner cases, random sweeps on three configurations.
module tb_alu_seq;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq_if #(.WIDTH(4), .N_OPS(3)) ifa ();
    alu_seq_if #(.WIDTH(8), .N_OPS(5)) ifb ();
    alu_seq_if #(.WIDTH(4), .N_OPS(1)) ifc ();

    alu_seq #(.WIDTH(4), .N_OPS(3)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    alu_seq #(.WIDTH(8), .N_OPS(5)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    alu_seq #(.WIDTH(4), .N_OPS(1)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] din;
        logic [1:0]  op;
        logic [5:0]  res;
        logic [3:0]  sum;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic [63:0] din, input logic [1:0] dop, input logic v);
        case (which)
            0: begin ifa.in = din[11:0]; ifa.op = dop; ifa.in_valid = v; end
            1: begin ifb.in = din[39:0]; ifb.op = dop; ifb.in_valid = v; end
            default: begin ifc.in = din[3:0]; ifc.op = dop; ifc.in_valid = v; end
        endcase
    endtask

    task automatic get_out(input int which, output logic [63:0] res, output logic [63:0] sm,
                           output logic ov, output logic z, output logic ovld);
        case (which)
            0: begin res = 64'(ifa.result); sm = 64'(ifa.sum); ov = ifa.ovf; z = ifa.zero; ovld = ifa.out_valid; end
            1: begin res = 64'(ifb.result); sm = 64'(ifb.sum); ov = ifb.ovf; z = ifb.zero; ovld = ifb.out_valid; end
            default: begin res = 64'(ifc.result); sm = 64'(ifc.sum); ov = ifc.ovf; z = ifc.zero; ovld = ifc.out_valid; end
        endcase
    endtask

    // Issue one request (out_ready assumed high), wait for the result, let it be consumed.
    task automatic do_req(input int which, input logic [63:0] din, input logic [1:0] dop,
                          output logic [63:0] res, output logic [63:0] sm,
                          output logic ov, output logic z, output int lat);
        logic ovld;
        drive(which, din, dop, 1'b1);
        @(posedge clk); #1;
        drive(which, din, dop, 1'b0);
        lat  = 0;
        ovld = 1'b0;
        res  = '0; sm = '0; ov = 1'b0; z = 1'b0;
        while (!ovld && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            get_out(which, res, sm, ov, z, ovld);
        end
        if (!ovld) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: dut %0d gave no out_valid within %0d edges", which, lat);
        end
        @(posedge clk); #1;
    endtask

    function automatic void ref_model(input logic [63:0] din, input logic [1:0] dop, input int w, input int n,
                                      output logic [63:0] res, output logic ov, output logic z);
        logic [63:0] fmask, f, acc;
        fmask = (64'd1 << w) - 64'd1;
        acc   = (dop == 2'b11) ? fmask : 64'd0;
        for (int k = 0; k < n; k++) begin
            f = (din >> (k * w)) & fmask;
            case (dop)
                2'b00:   acc = acc + f;
                2'b01:   acc = acc + 64'($countones(f));
                2'b10:   if (f > acc) acc = f;
                default: if (f < acc) acc = f;
            endcase
        end
        res = acc;
        ov  = (dop == 2'b00) && (acc > fmask);
        z   = (acc == 64'd0);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] res, sm, exp_r, mask, din;
        logic        ov, z, exp_o, exp_z;
        logic [1:0]  dop;
        int          lat, cyc;
        int          cw[3];
        int          cn[3];

        vecs[0]  = '{12'h321, 2'b00, 6'd6,  4'd6,  1'b0, 1'b0};
        vecs[1]  = '{12'hFFF, 2'b00, 6'd45, 4'd13, 1'b1, 1'b0};
        vecs[2]  = '{12'hF0F, 2'b01, 6'd8,  4'd8,  1'b0, 1'b0};
        vecs[3]  = '{12'h3A7, 2'b10, 6'd10, 4'd10, 1'b0, 1'b0};
        vecs[4]  = '{12'h3A7, 2'b11, 6'd3,  4'd3,  1'b0, 1'b0};
        vecs[5]  = '{12'h555, 2'b10, 6'd5,  4'd5,  1'b0, 1'b0};
        vecs[6]  = '{12'h555, 2'b11, 6'd5,  4'd5,  1'b0, 1'b0};
        vecs[7]  = '{12'h000, 2'b00, 6'd0,  4'd0,  1'b0, 1'b1};
        vecs[8]  = '{12'h000, 2'b11, 6'd0,  4'd0,  1'b0, 1'b1};
        vecs[9]  = '{12'hFFF, 2'b01, 6'd12, 4'd12, 1'b0, 1'b0};
        vecs[10] = '{12'h0F0, 2'b10, 6'd15, 4'd15, 1'b0, 1'b0};

        cw[0] = 4; cn[0] = 3;
        cw[1] = 8; cn[1] = 5;
        cw[2] = 4; cn[2] = 1;

        rst_n = 1'b0;
        for (int w = 0; w < 3; w++) drive(w, 64'd0, 2'b00, 1'b0);
        ifa.out_ready = 1'b1;
        ifb.out_ready = 1'b1;
        ifc.out_ready = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_result",    64'(ifa.result),    64'd0);
        check("rst_sum",       64'(ifa.sum),       64'd0);
        check("rst_ovf",       64'(ifa.ovf),       64'd0);
        check("rst_zero",      64'(ifa.zero),      64'd0);
        check("rst_out_valid", 64'(ifa.out_valid), 64'd0);
        check("rst_in_ready",  64'(ifa.in_ready),  64'd1);
        check("rst_b_ready",   64'(ifb.in_ready),  64'd1);
        check("rst_c_ready",   64'(ifc.in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Handshake timing for a single SUM request.
        check("t1_ready_pre", 64'(ifa.in_ready), 64'd1);
        drive(0, 64'h321, 2'b00, 1'b1);
        @(posedge clk); #1;
        drive(0, 64'h321, 2'b00, 1'b0);
        check("t1_ready_e0", 64'(ifa.in_ready),  64'd0);
        check("t1_valid_e0", 64'(ifa.out_valid), 64'd0);
        @(posedge clk); #1;
        check("t1_ready_e1", 64'(ifa.in_ready),  64'd0);
        check("t1_valid_e1", 64'(ifa.out_valid), 64'd0);
        @(posedge clk); #1;
        check("t1_ready_e2", 64'(ifa.in_ready),  64'd0);
        check("t1_valid_e2", 64'(ifa.out_valid), 64'd0);
        @(posedge clk); #1;
        check("t1_ready_e3", 64'(ifa.in_ready),  64'd0);
        check("t1_valid_e3", 64'(ifa.out_valid), 64'd1);
        check("t1_result",   64'(ifa.result),    64'd6);
        check("t1_zero",     64'(ifa.zero),      64'd0);
        @(posedge clk); #1;
        check("t1_valid_e4", 64'(ifa.out_valid), 64'd0);
        check("t1_ready_e4", 64'(ifa.in_ready),  64'd1);

        // Directed vector table on the default configuration.
        for (int i = 0; i < 11; i++) begin
            do_req(0, 64'(vecs[i].din), vecs[i].op, res, sm, ov, z, lat);
            check($sformatf("vec%0d_result", i), res,     64'(vecs[i].res));
            check($sformatf("vec%0d_sum", i),    sm,      64'(vecs[i].sum));
            check($sformatf("vec%0d_ovf", i),    64'(ov), 64'(vecs[i].ovf));
            check($sformatf("vec%0d_zero", i),   64'(z),  64'(vecs[i].zero));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
        end

        // Backpressure: result held while out_ready is low, new requests ignored.
        ifa.out_ready = 1'b0;
        drive(0, 64'h3A7, 2'b10, 1'b1);
        @(posedge clk); #1;
        drive(0, 64'h3A7, 2'b10, 1'b0);
        cyc = 0;
        while (!ifa.out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp_latency", 64'(cyc), 64'd3);
        for (int k = 0; k < 5; k++) begin
            drive(0, 64'h111, 2'b00, 1'b1);
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_valid", k),  64'(ifa.out_valid), 64'd1);
            check($sformatf("bp_hold%0d_result", k), 64'(ifa.result),    64'd10);
            check($sformatf("bp_hold%0d_ready", k),  64'(ifa.in_ready),  64'd0);
        end
        drive(0, 64'h111, 2'b00, 1'b0);
        ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 64'(ifa.out_valid), 64'd0);
        check("bp_release_ready", 64'(ifa.in_ready),  64'd1);
        repeat (4) @(posedge clk);
        #1;
        check("bp_idle_valid",  64'(ifa.out_valid), 64'd0);
        check("bp_idle_result", 64'(ifa.result),    64'd10);
        check("bp_idle_ready",  64'(ifa.in_ready),  64'd1);

        // Reset during the second RUN cycle discards the request without a clock.
        drive(0, 64'h321, 2'b00, 1'b1);
        @(posedge clk); #1;
        drive(0, 64'h321, 2'b00, 1'b0);
        @(posedge clk); #1;
        check("mrst_pre_ready",  64'(ifa.in_ready), 64'd0);
        check("mrst_pre_result", 64'(ifa.result),   64'd10);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_valid",  64'(ifa.out_valid), 64'd0);
        check("mrst_result", 64'(ifa.result),    64'd0);
        check("mrst_ready",  64'(ifa.in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("mrst_after%0d_valid", k), 64'(ifa.out_valid), 64'd0);
        end
        do_req(0, 64'h000, 2'b00, res, sm, ov, z, lat);
        check("mrst_new_result", res,     64'd0);
        check("mrst_new_zero",   64'(z),  64'd1);
        check("mrst_new_ovf",    64'(ov), 64'd0);

        // Random sweeps against the reference reduction on all three configurations.
        for (int c = 0; c < 3; c++) begin
            mask = (64'd1 << (cw[c] * cn[c])) - 64'd1;
            for (int t = 0; t < 200; t++) begin
                din = {$urandom(), $urandom()} & mask;
                dop = 2'($urandom_range(0, 3));
                do_req(c, din, dop, res, sm, ov, z, lat);
                ref_model(din, dop, cw[c], cn[c], exp_r, exp_o, exp_z);
                check($sformatf("rnd_c%0d_t%0d_result", c, t),  res,      exp_r);
                check($sformatf("rnd_c%0d_t%0d_ovf", c, t),     64'(ov),  64'(exp_o));
                check($sformatf("rnd_c%0d_t%0d_zero", c, t),    64'(z),   64'(exp_z));
                check($sformatf("rnd_c%0d_t%0d_latency", c, t), 64'(lat), 64'(cn[c]));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor of the combinational 12-bit-in ALU.
- Accepts a packed bus of N_OPS operands, each WIDTH bits, through a valid/ready handshake.
- Reduces the operands serially, one field per cycle, using a selectable mode: SUM, POPCNT, MAX or MIN.
- Presents a full-precision result, plus flags, on a held valid/ready output.
- Default parameters reproduce the legacy 12-bit input / 4-bit result case.

Parameters:
- WIDTH, 4: bits per operand field.
- N_OPS, 3: number of operand fields. Must be >= 1; elaboration fails otherwise.
- OUT_W, WIDTH+$clog2(N_OPS) (0 when N_OPS=1): result width. This is exact for the worst-case SUM and always holds POPCNT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in  in  WIDTH*N_OPS  packed operands. Field k is in[k*WIDTH +: WIDTH]; field 0 is processed first.
- op  in  2  mode: 00 SUM, 01 POPCNT, 10 MAX, 11 MIN.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- result  out  OUT_W  reduction result, zero-extended.
- sum  out  WIDTH  result[WIDTH-1:0] (legacy-width view; wraps).
- ovf  out  1  result exceeds 2**WIDTH-1. Meaningful for SUM; 0 in all other modes.
- zero  out  1  result == 0.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (async assert, sync deassert by the clock edge):
  - state=IDLE, acc=0, idx=0.
  - result=0, sum=0, ovf=0, zero=0, out_valid=0, in_ready=1.
  - Reset asserted mid-operation discards the in-flight request immediately; no partial result is ever shown.
- FSM has three states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch `in` and `op` into internal registers, set idx=0, load the mode identity into acc, go to RUN.
    - Identities: SUM 0, POPCNT 0, MAX 0, MIN all-ones of WIDTH.
  - RUN: in_ready=0. Each cycle: acc <= step(acc, field[idx], op); idx <= idx+1.
    - When idx==N_OPS-1, go to DONE with out_valid=1 on the same edge.
  - DONE: out_valid=1. result and flags are held stable until out_ready=1. On out_valid&&out_ready, go to IDLE and clear out_valid.
- Latency and throughput:
  - out_valid rises exactly N_OPS clock edges after the accepting edge.
  - in_ready=0 in RUN and DONE, so no request is accepted in the cycle the result is consumed.
  - Minimum period is N_OPS+2 cycles per request with out_ready tied high.
- Per-mode step rules:
  - SUM: acc + field, OUT_W-bit, never wraps internally.
  - POPCNT: acc + number of ones in field.
  - MAX / MIN: unsigned compare; on ties acc is kept.
- Flags are registered together with result, in the edge entering DONE. They are never combinational off acc.
  - ovf = (op==SUM) && (result > 2**WIDTH-1).
  - zero = (result==0).
- Input-side boundaries:
  - Changes on in, op or in_valid outside IDLE have no effect.
  - in_valid may drop without being accepted; nothing is latched.
- Output-side boundaries:
  - out_ready asserted while out_valid=0 is ignored.
  - Outputs keep their last value in IDLE/RUN, but out_valid=0 there. The exception is reset, which zeroes them.
- N_OPS=1 case:
  - idx is a 1-bit register held at 0.
  - RUN lasts one cycle.
  - OUT_W=WIDTH, so ovf is always 0.

Decomposition:
- Package alu_pkg:
  - op encodings OP_SUM, OP_POPCNT, OP_MAX, OP_MIN.
  - FSM state encodings S_IDLE, S_RUN, S_DONE.
  - Function for the per-mode identity value.
- Sub-module alu_step: purely combinational (acc, operand, op) -> next acc, parametrised by WIDTH/OUT_W. It contains the popcount tree and the compare logic.
- alu_seq holds the FSM, index counter, latched operands, accumulator and flag registers.

Test Plan (WIDTH=4, N_OPS=3, out_ready=1 unless stated):
1. in=12'h321, op=SUM: accept at edge E; out_valid at E+3 with result=6, sum=6, ovf=0, zero=0. in_ready=0 for edges E+1..E+3 and returns to 1 the cycle after the result is consumed.
2. in=12'hFFF, op=SUM: result=45, sum=13, ovf=1. Then in=12'hF0F, op=POPCNT: result=8, ovf=0.
3. in=12'h3A7: op=MAX gives result=10; op=MIN gives result=3. For in=12'h555, MAX and MIN both give 5.
4. Backpressure: out_ready=0 for 5 cycles after out_valid. result, flags and out_valid are held; in_ready=0; a new in_valid with in=12'h111 is ignored. When out_ready=1, out_valid drops next edge and in_ready returns to 1.
5. Reset mid-operation: rst_n low in the second RUN cycle. out_valid, result and in_ready go to 0/0/1 without a clock. After release, a fresh request with in=12'h000, op=SUM gives result=0, zero=1.
6. Regression: sweep 200 random (in, op) pairs against a reference model of the reduction. Repeat with WIDTH=8, N_OPS=5 and WIDTH=4, N_OPS=1.
